// File: rtl/pes_demux_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pes_demux_pkg
//  Brief    : Shared lane count, select width and scheduler state encoding
//             for the 1:8 demux scheduler and its lane arbiters.
//  Revision : 1.0 - initial release
// ============================================================================
package pes_demux_pkg;

  localparam int NLANES = 8;
  localparam int SELW   = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    XFER = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/pes_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : pes_rr_pick
//  Brief    : Combinational round-robin finder. Returns the first set mask
//             bit after i_last (wrapping), with i_last itself checked last.
//  Revision : 1.0 - initial release
// ============================================================================
module pes_rr_pick
  import pes_demux_pkg::*;
(
  input  logic [NLANES-1:0] i_mask,
  input  logic [SELW-1:0]   i_last,
  output logic              o_found,
  output logic [SELW-1:0]   o_next
);

  logic [SELW-1:0] w_idx;

  // Walk last+1 .. last+8; the 3-bit wrap makes last+8 land on last itself
  always_comb begin
    o_found = 1'b0;
    o_next  = i_last;
    w_idx   = i_last;
    for (int i = 1; i <= NLANES; i++) begin
      w_idx = i_last + SELW'(i);
      if (!o_found && i_mask[w_idx]) begin
        o_found = 1'b1;
        o_next  = w_idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pes_demux_sched.sv
`default_nettype none
// ============================================================================
//  Module   : pes_demux_sched
//  Brief    : Round-robin burst scheduler driving a 1:8 demux. Grants the
//             input stream to one enabled lane for up to BURST beats, then
//             spends one ARB cycle choosing the next enabled lane. Data and
//             valid pass through combinationally; unselected lanes see zero.
//  Options  : PES_DEMUX_SCHED_IDLE_RELEASE_EN - an input gap after at least
//             one beat of a burst releases the grant early.
//  Revision : 1.0 - initial release
// ============================================================================
module pes_demux_sched
  import pes_demux_pkg::*;
#(
  parameter int DW    = 1,
  parameter int BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [DW-1:0]        in_data,
  output logic                 in_ready,
  input  logic [NLANES-1:0]    lane_en,
  output logic [NLANES-1:0]    out_valid,
  output logic [NLANES*DW-1:0] out_data,
  input  logic [NLANES-1:0]    out_ready,
  output logic [SELW-1:0]      sel,
  output logic                 busy
);

  localparam int CW = $clog2(BURST + 1);

  state_t          r_st;
  logic [SELW-1:0] r_sel;
  logic [SELW-1:0] r_last;
  logic [CW-1:0]   r_cnt;
  logic            r_busy;

  logic            w_xfer;
  logic            w_lane_ok;
  logic            w_hs;
  logic            w_burst_done;
  logic            w_release;
  logic            w_found;
  logic [SELW-1:0] w_next;

  pes_rr_pick u_pick (
    .i_mask  (lane_en),
    .i_last  (r_last),
    .o_found (w_found),
    .o_next  (w_next)
  );

  assign w_xfer       = (r_st == XFER);
  assign w_lane_ok    = lane_en[r_sel];
  assign in_ready     = w_xfer && out_ready[r_sel] && w_lane_ok;
  assign w_hs         = in_valid && in_ready;
  assign w_burst_done = (r_cnt == CW'(BURST - 1));
  assign sel          = r_sel;
  assign busy         = r_busy;

`ifdef PES_DEMUX_SCHED_IDLE_RELEASE_EN
  assign w_release = !in_valid && (r_cnt != '0);
`else
  assign w_release = 1'b0;
`endif

  // Per-lane gating: only the granted lane sees valid/data, and only in XFER
  for (genvar k = 0; k < NLANES; k++) begin : g_lane
    assign out_valid[k]         = w_xfer && (r_sel == SELW'(k)) && in_valid && lane_en[k];
    assign out_data[k*DW +: DW] = (w_xfer && (r_sel == SELW'(k))) ? in_data : '0;
  end

  // Scheduler FSM: idle wait, one-cycle arbitration, burst transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st   <= IDLE;
      r_sel  <= '0;
      r_last <= SELW'(NLANES - 1);
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else begin
      unique case (r_st)
        IDLE: begin
          if (in_valid && |lane_en) begin
            r_st   <= ARB;
            r_busy <= 1'b1;
          end
        end
        ARB: begin
          if (w_found) begin
            r_sel  <= w_next;
            r_last <= w_next;
            r_cnt  <= '0;
            r_st   <= XFER;
          end else begin
            r_st   <= IDLE;
            r_busy <= 1'b0;
          end
        end
        XFER: begin
          if (!w_lane_ok) begin
            r_st <= ARB;
          end else if (w_hs) begin
            if (w_burst_done) begin
              r_cnt <= '0;
              r_st  <= ARB;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end else if (w_release) begin
            r_st <= ARB;
          end
        end
        default: begin
          r_st   <= IDLE;
          r_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pes_demux_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pes_demux_sched
//  Brief    : Directed self-checking bench for pes_demux_sched (DW=8, BURST=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pes_demux_sched;

  localparam int DW    = 8;
  localparam int BURST = 4;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic [7:0]    lane_en;
  logic [7:0]    out_valid;
  logic [8*DW-1:0] out_data;
  logic [7:0]    out_ready;
  logic [2:0]    sel;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;
  int beats [8];

  pes_demux_sched #(.DW(DW), .BURST(BURST)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .lane_en   (lane_en),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .sel       (sel),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count accepted beats per lane
  initial for (int k = 0; k < 8; k++) beats[k] = 0;
  always @(posedge clk) begin
    if (rst_n && in_valid && in_ready)
      for (int k = 0; k < 8; k++)
        if (out_valid[k]) beats[k] = beats[k] + 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    in_valid  = 1'b0;
    in_data   = '0;
    lane_en   = 8'h00;
    out_ready = 8'hFF;
    rst_n     = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    in_valid  = 1'b1;
    in_data   = 8'hA5;
    lane_en   = 8'hFF;
    out_ready = 8'hFF;
    rst_n     = 1'b0;
    #1;
    n_checks++;
    if (sel !== 3'd0 || busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 8'h00 || out_data !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_state: sel=%0d busy=%b in_ready=%b out_valid=%h out_data=%h, required 0/0/0/00/0",
               sel, busy, in_ready, out_valid, out_data);
    end
    tick;
  endtask

  task automatic test_rotation;
    logic       exp_rdy;
    int         exp_lane;
    logic [63:0] exp_data;
    do_reset;
    lane_en  = 8'hFF;
    in_valid = 1'b1;
    for (int c = 0; c < 47; c++) begin
      in_data = DW'(c + 1);
      #1;
      exp_rdy  = 1'b0;
      exp_lane = 0;
      if (c >= 2 && ((c - 2) % 5) < 4) begin
        exp_rdy  = 1'b1;
        exp_lane = ((c - 2) / 5) % 8;
      end
      exp_data = exp_rdy ? ({56'h0, in_data} << (exp_lane * 8)) : 64'h0;
      n_checks++;
      if (in_ready !== exp_rdy || busy !== (c >= 1)) begin
        n_fail++;
        $display("FAIL rot_ready c=%0d: in_ready=%b busy=%b, required %b/%b", c, in_ready, busy, exp_rdy, (c >= 1));
      end
      n_checks++;
      if (out_valid !== (exp_rdy ? (8'h01 << exp_lane) : 8'h00) || out_data !== exp_data ||
          (exp_rdy && sel !== 3'(exp_lane))) begin
        n_fail++;
        $display("FAIL rot_lane c=%0d: sel=%0d out_valid=%h out_data=%h, required lane %0d data %h",
                 c, sel, out_valid, out_data, exp_lane, exp_data);
      end
      tick;
    end
  endtask

  task automatic test_two_lanes;
    logic exp_rdy;
    int   exp_lane;
    do_reset;
    lane_en  = 8'b0010_0100;
    in_valid = 1'b1;
    for (int c = 0; c < 17; c++) begin
      in_data = DW'(8'h40 + c);
      #1;
      exp_rdy  = 1'b0;
      exp_lane = 0;
      if (c >= 2 && ((c - 2) % 5) < 4) begin
        exp_rdy  = 1'b1;
        exp_lane = (((c - 2) / 5) % 2 == 0) ? 2 : 5;
      end
      n_checks++;
      if (in_ready !== exp_rdy || (out_valid & 8'b1101_1011) !== 8'h00 ||
          out_valid !== (exp_rdy ? (8'h01 << exp_lane) : 8'h00)) begin
        n_fail++;
        $display("FAIL two_lanes c=%0d: in_ready=%b out_valid=%h, required %b lane %0d", c, in_ready, out_valid, exp_rdy, exp_lane);
      end
      tick;
    end
  endtask

  task automatic test_lane_drop;
    int base3;
    do_reset;
    base3    = beats[3];
    lane_en  = 8'b0001_1000;
    in_valid = 1'b1;
    in_data  = 8'h33;
    tick;                       // IDLE
    tick;                       // ARB
    tick;                       // beat 1 on lane 3
    tick;                       // beat 2 on lane 3
    lane_en = 8'b0001_0000;
    #1;
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 8'h00) begin
      n_fail++;
      $display("FAIL drop_gate: in_ready=%b out_valid=%h, required 0/00", in_ready, out_valid);
    end
    tick;                       // ARB
    n_checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_arb: in_ready=%b busy=%b, required 0/1", in_ready, busy);
    end
    tick;
    n_checks++;
    if (sel !== 3'd4 || in_ready !== 1'b1 || out_valid !== 8'h10) begin
      n_fail++;
      $display("FAIL drop_next: sel=%0d in_ready=%b out_valid=%h, required 4/1/10", sel, in_ready, out_valid);
    end
    n_checks++;
    if (beats[3] - base3 !== 2) begin
      n_fail++;
      $display("FAIL drop_beats: lane3 beats=%0d, required 2", beats[3] - base3);
    end
    tick;
  endtask

  task automatic test_stall;
    int base0;
    do_reset;
    base0    = beats[0];
    lane_en  = 8'h01;
    in_valid = 1'b1;
    in_data  = 8'h5A;
    tick;                       // IDLE
    tick;                       // ARB
    tick;                       // beat 1
    tick;                       // beat 2
    out_ready = 8'h00;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 8'h01 || sel !== 3'd0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL stall c=%0d: in_ready=%b out_valid=%h sel=%0d busy=%b, required 0/01/0/1",
                 c, in_ready, out_valid, sel, busy);
      end
      tick;
    end
    out_ready = 8'hFF;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_resume c=%0d: in_ready=%b, required 1", c, in_ready);
      end
      tick;
    end
    #1;
    n_checks++;
    if (in_ready !== 1'b0 || beats[0] - base0 !== BURST) begin
      n_fail++;
      $display("FAIL stall_done: in_ready=%b beats=%0d, required 0/%0d", in_ready, beats[0] - base0, BURST);
    end
    tick;
    n_checks++;
    if (in_ready !== 1'b1 || sel !== 3'd0) begin
      n_fail++;
      $display("FAIL stall_regrant: in_ready=%b sel=%0d, required 1/0", in_ready, sel);
    end
    tick;
  endtask

  task automatic test_gap;
    int base0;
    do_reset;
    base0    = beats[0];
    lane_en  = 8'h03;
    in_valid = 1'b1;
    in_data  = 8'h77;
    tick;                       // IDLE
    tick;                       // ARB
    tick;                       // beat 1 on lane 0
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 8'h00) begin
      n_fail++;
      $display("FAIL gap_valid: out_valid=%h, required 00", out_valid);
    end
    tick;
    in_valid = 1'b1;
`ifdef PES_DEMUX_SCHED_IDLE_RELEASE_EN
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL gap_release_arb: in_ready=%b, required 0", in_ready);
    end
    tick;
    n_checks++;
    if (sel !== 3'd1 || in_ready !== 1'b1 || beats[0] - base0 !== 1) begin
      n_fail++;
      $display("FAIL gap_release_next: sel=%0d in_ready=%b lane0 beats=%0d, required 1/1/1",
               sel, in_ready, beats[0] - base0);
    end
`else
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (in_ready !== 1'b1 || sel !== 3'd0) begin
        n_fail++;
        $display("FAIL gap_hold c=%0d: in_ready=%b sel=%0d, required 1/0", c, in_ready, sel);
      end
      tick;
    end
    #1;
    n_checks++;
    if (in_ready !== 1'b0 || beats[0] - base0 !== BURST) begin
      n_fail++;
      $display("FAIL gap_hold_done: in_ready=%b lane0 beats=%0d, required 0/%0d", in_ready, beats[0] - base0, BURST);
    end
    tick;
    n_checks++;
    if (sel !== 3'd1) begin
      n_fail++;
      $display("FAIL gap_hold_next: sel=%0d, required 1", sel);
    end
`endif
    tick;
  endtask

  task automatic test_no_lanes;
    do_reset;
    lane_en  = 8'h00;
    in_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_checks++;
      if (in_ready !== 1'b0 || busy !== 1'b0 || out_valid !== 8'h00) begin
        n_fail++;
        $display("FAIL no_lanes c=%0d: in_ready=%b busy=%b out_valid=%h, required 0/0/00", c, in_ready, busy, out_valid);
      end
      tick;
    end
  endtask

  task automatic test_async_reset;
    do_reset;
    lane_en  = 8'h20;
    in_valid = 1'b1;
    in_data  = 8'hC3;
    tick;                       // IDLE
    tick;                       // ARB
    tick;                       // XFER on lane 5
    #1;
    n_checks++;
    if (sel !== 3'd5 || out_valid !== 8'h20 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_pre: sel=%0d out_valid=%h in_ready=%b, required 5/20/1", sel, out_valid, in_ready);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (sel !== 3'd0 || out_valid !== 8'h00 || in_ready !== 1'b0 || busy !== 1'b0 || out_data !== 64'h0) begin
      n_fail++;
      $display("FAIL areset_now: sel=%0d out_valid=%h in_ready=%b busy=%b out_data=%h, required 0/00/0/0/0",
               sel, out_valid, in_ready, busy, out_data);
    end
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    lane_en   = 8'h00;
    out_ready = 8'hFF;
    #2;
    test_reset;
    test_rotation;
    test_two_lanes;
    test_lane_drop;
    test_stall;
    test_gap;
    test_no_lanes;
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pes_demux_sched.md
# pes_demux_sched

Round-robin scheduler that owns a 1:8 demultiplexer. It accepts a single valid/ready input stream and grants it to one of eight output lanes at a time. Each grant lasts a burst of up to BURST beats, then the grant rotates to the next enabled lane. It sits directly in front of the 1:8 demux datapath and drives its 3-bit select. It also gates per-lane valid so that unselected lanes see zero data and no valid.

## Interface
Parameters:
- DW, 1, data width per beat
- BURST, 4, beats per grant before rotation (legal range 1..255)

Ports:
- clk  input  1  single clock, rising-edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream beat valid
- in_data  input  DW  upstream beat data
- in_ready  output  1  upstream beat accepted when in_valid && in_ready
- lane_en  input  8  per-lane enable mask; bit k=0 excludes lane k from arbitration
- out_valid  output  8  one-hot lane valid
- out_data  output  8*DW  lane k occupies bits [k*DW +: DW]; all unselected lanes are 0
- out_ready  input  8  per-lane downstream ready
- sel  output  3  demux select = currently granted lane
- busy  output  1  high in ARB or XFER

## Operation
- Registered state: st (IDLE, ARB, XFER), sel, last (the last granted lane), beat counter cnt with width $clog2(BURST+1).
- IDLE:
  - in_ready=0, out_valid=0.
  - Moves to ARB when in_valid && |lane_en.
- ARB (exactly one cycle):
  - in_ready=0, out_valid=0.
  - next = first k with lane_en[k]=1, searching last+1, last+2, ... modulo 8, with last itself searched last.
  - If a lane is found: sel<=next, last<=next, cnt<=0, go to XFER.
  - If lane_en==0: go to IDLE and leave sel unchanged.
- XFER:
  - out_valid[sel] = in_valid && lane_en[sel]; all other bits are 0.
  - out_data lane sel = in_data; all other lanes are 0.
  - in_ready = out_ready[sel] && lane_en[sel].
  - Each handshake increments cnt.
  - When the handshake would make cnt==BURST, go to ARB.
  - When lane_en[sel]==0, go to ARB that cycle. No beat transfers, because in_ready is gated.
- Stalls: in_valid low or out_ready[sel] low holds XFER with cnt unchanged (see Configuration for the exception).
- Data is combinational pass-through in XFER. The block does not buffer data.

## Timing
- Reset values: st=IDLE, sel=0, last=7 (so the first grant goes to the lowest enabled lane), cnt=0, in_ready=0, out_valid=0, out_data=0, busy=0.
- Rotation gap:
  - Startup costs 2 cycles: IDLE to ARB, then ARB to XFER.
  - Each rotation costs 1 ARB cycle with no transfer.
  - Sustained throughput is BURST/(BURST+1) beats per cycle.
- Latency: in to out is 0 cycles (combinational) in XFER.
- Single enabled lane: after each burst the block rotates to the same lane through ARB.
- lane_en changes take effect the same cycle for gating and on the next edge for state.
- Reset asserted mid-burst returns all registers to their reset values immediately, asynchronously. The in-flight beat is not accepted unless a handshake completed on a prior edge.
- BURST=1: rotates after every beat.

## Configuration
- Macro PES_DEMUX_SCHED_IDLE_RELEASE_EN.
- Defined: in XFER, a cycle with in_valid=0 and cnt>0 releases the grant early and goes to ARB.
- Undefined: the grant is held until BURST beats complete or lane_en[sel] drops, regardless of input gaps.

## Structure
- Package pes_demux_pkg holds:
  - NLANES=8 and SELW=3
  - the state enum (IDLE, ARB, XFER)
- Sub-module pes_rr_pick: combinational round-robin finder.
  - Inputs: 8-bit mask and 3-bit last.
  - Outputs: found flag and 3-bit next.
  - Reusable by other lane arbiters in the design.

## Test plan
- Reset, lane_en=8'hFF, BURST=4, in_valid=1, all out_ready=1 -> grants go to lanes 0,1,...,7,0 with 4 beats each. in_ready is low for exactly 1 cycle between bursts, and sel matches the one-hot out_valid.
- lane_en=8'b0010_0100 -> only lanes 2 and 5 alternate, and no out_valid ever appears on other lanes.
- Mid-burst, after 2 beats on lane 3, clear lane_en[3] -> the same cycle gives in_ready=0 and out_valid=0. The next grant goes to lane 4, and lane 3 received exactly 2 beats.
- out_ready[sel]=0 for 5 cycles mid-burst -> cnt holds and the grant is kept. The burst completes with exactly 4 beats after ready returns.
- in_valid gap of 1 cycle after beat 1:
  - With the macro defined -> the block rotates to the next lane.
  - Without it -> the same lane receives 4 beats.
- lane_en=0 with in_valid=1 -> the block stays in IDLE with in_ready=0 and busy=0. Asserting rst_n=0 during XFER -> sel=0, out_valid=0 and in_ready=0 immediately.
